// File: rtl/id_control_stage_pkg.sv
// id_control_stage_pkg: MIPS opcodes, ALUOp codes, control vector and halt-drain FSM states.
package id_control_stage_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [2:0] OPG_IMM   = 3'b001;
  localparam logic [2:0] OPG_LOAD  = 3'b100;
  localparam logic [2:0] OPG_STORE = 3'b101;
  localparam logic [3:0] ALUOP_RTYPE  = 4'b0000;
  localparam logic [3:0] ALUOP_MEM    = 4'b0001;
  localparam logic [3:0] ALUOP_BRANCH = 4'b0100;
  localparam logic       ALUOP_IMM_MSB = 1'b1;
  localparam logic [2:0] INMED_ADDI = 3'b000;
  localparam logic [2:0] INMED_SLTI = 3'b010;
  localparam logic [2:0] INMED_ANDI = 3'b100;
  localparam logic [2:0] INMED_ORI  = 3'b101;
  localparam logic [2:0] INMED_XORI = 3'b110;
  localparam logic [2:0] INMED_LUI  = 3'b111;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_HALTED = 2'd2} state_e;
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       branch_ne;
    logic       jump;
  } ctrl_t;
endpackage

// File: rtl/id_control_stage_main_decoder.sv
// main_decoder: combinational opcode -> control vector, with HALT and unknown-opcode flags.
module main_decoder
  import id_control_stage_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       halt_o,
  output logic       illegal_o
);
  logic [2:0] grp;
  assign grp = opcode_i[5:3];
  always_comb begin
    ctrl_o = '0;
    halt_o = 1'b0;
    illegal_o = 1'b0;
    if (opcode_i == OP_RTYPE) begin
      ctrl_o.alu_op = ALUOP_RTYPE;
      ctrl_o.reg_dst = 1'b1;
      ctrl_o.reg_write = 1'b1;
    end else if (grp == OPG_LOAD) begin
      ctrl_o.alu_op = ALUOP_MEM;
      ctrl_o.alu_src = 1'b1;
      ctrl_o.mem_read = 1'b1;
      ctrl_o.mem_to_reg = 1'b1;
      ctrl_o.reg_write = 1'b1;
    end else if (grp == OPG_STORE) begin
      ctrl_o.alu_op = ALUOP_MEM;
      ctrl_o.alu_src = 1'b1;
      ctrl_o.mem_write = 1'b1;
    end else if (opcode_i == OP_BEQ || opcode_i == OP_BNE) begin
      ctrl_o.alu_op = ALUOP_BRANCH;
      ctrl_o.branch = opcode_i[0] == 1'b0;
      ctrl_o.branch_ne = opcode_i[0];
    end else if (grp == OPG_IMM) begin
      ctrl_o.alu_op = {ALUOP_IMM_MSB, opcode_i[2:0]};
      ctrl_o.alu_src = 1'b1;
      ctrl_o.reg_write = 1'b1;
    end else if (opcode_i == OP_J || opcode_i == OP_JAL) begin
      ctrl_o.jump = 1'b1;
      ctrl_o.reg_write = opcode_i[0];
      ctrl_o.alu_op = opcode_i[0] ? ALUOP_MEM : ALUOP_RTYPE;
    end else if (opcode_i == OP_HALT) begin
      halt_o = 1'b1;
    end else begin
      illegal_o = 1'b1;
    end
  end
endmodule

// File: rtl/id_control_stage.sv
// id_control_stage: ID decode + ID/EX control register with stall/flush bubbles and HALT drain FSM.
// Optional ILLEGAL_OPCODE_TRAP_EN: unknown opcodes become bubbles, set sticky o_illegal and drain.
module id_control_stage
  import id_control_stage_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W = 3
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_instruction,
  input  logic        i_valid,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic [3:0]  o_ALUOp,
  output logic        o_ALUSrc,
  output logic        o_RegDst,
  output logic        o_RegWrite,
  output logic        o_MemRead,
  output logic        o_MemWrite,
  output logic        o_MemtoReg,
  output logic        o_Branch,
  output logic        o_BranchNE,
  output logic        o_Jump,
  output logic        o_valid,
  output logic        o_halted
`ifdef ILLEGAL_OPCODE_TRAP_EN
  , output logic      o_illegal
`endif
);
  ctrl_t ctrl_q, ctrl_d, dec_ctrl;
  logic valid_q, valid_d, dec_halt, dec_illegal, trap_op, capture, load, take;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  main_decoder u_dec (
    .opcode_i (i_instruction[31:26]),
    .ctrl_o   (dec_ctrl),
    .halt_o   (dec_halt),
    .illegal_o(dec_illegal)
  );
`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic illegal_q, illegal_d;
  assign trap_op = dec_halt | dec_illegal;
  assign illegal_d = illegal_q | (capture & dec_illegal);
  assign o_illegal = illegal_q;
`else
  assign trap_op = dec_halt;
`endif
  assign capture = state_q == ST_RUN && i_valid && !i_stall && !i_flush;
  // Once draining or halted, nothing but bubbles enters ID/EX.
  assign load = !i_stall || i_flush || state_q == ST_HALTED;
  assign take = capture && !trap_op;
  assign ctrl_d = load ? (take ? dec_ctrl : '0) : ctrl_q;
  assign valid_d = load ? take : valid_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == ST_RUN && capture && trap_op) begin
      state_d = ST_DRAIN;
      cnt_d = '0;
    end else if (state_q == ST_DRAIN && !i_stall) begin
      state_d = cnt_q == CNT_W'(DRAIN_CYCLES - 1) ? ST_HALTED : ST_DRAIN;
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      ctrl_q <= '0;
      valid_q <= 1'b0;
      state_q <= ST_RUN;
      cnt_q <= '0;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      ctrl_q <= ctrl_d;
      valid_q <= valid_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end
  assign o_ALUOp = ctrl_q.alu_op;
  assign o_ALUSrc = ctrl_q.alu_src;
  assign o_RegDst = ctrl_q.reg_dst;
  assign o_RegWrite = ctrl_q.reg_write;
  assign o_MemRead = ctrl_q.mem_read;
  assign o_MemWrite = ctrl_q.mem_write;
  assign o_MemtoReg = ctrl_q.mem_to_reg;
  assign o_Branch = ctrl_q.branch;
  assign o_BranchNE = ctrl_q.branch_ne;
  assign o_Jump = ctrl_q.jump;
  assign o_valid = valid_q;
  assign o_halted = state_q == ST_HALTED;
endmodule

// File: tb/tb_id_control_stage.sv
// tb_id_control_stage: directed vector table plus hand sequences for stall/flush, HALT drain and reset.
module tb_id_control_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [3:0] alu_op;
  logic alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, branch, branch_ne, jump, o_valid, halted;
  int checks = 0, errors = 0;
`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic illegal;
`endif
  always #5 clk = ~clk;
  id_control_stage dut (
    .i_clock(clk), .i_reset(rst_n), .i_instruction(instr), .i_valid(valid),
    .i_stall(stall), .i_flush(flush), .o_ALUOp(alu_op), .o_ALUSrc(alu_src),
    .o_RegDst(reg_dst), .o_RegWrite(reg_write), .o_MemRead(mem_read),
    .o_MemWrite(mem_write), .o_MemtoReg(mem_to_reg), .o_Branch(branch),
    .o_BranchNE(branch_ne), .o_Jump(jump), .o_valid(o_valid), .o_halted(halted)
`ifdef ILLEGAL_OPCODE_TRAP_EN
    , .o_illegal(illegal)
`endif
  );
  // {ALUOp[4], ALUSrc, RegDst, RegWrite, MemRead, MemWrite, MemtoReg, Branch, BranchNE, Jump, valid, halted}
  typedef struct {
    logic [31:0] instr;
    logic valid, stall, flush;
    logic [14:0] exp;
    string name;
  } vec_t;
  localparam logic [14:0] BUBBLE = 15'b0;
  localparam logic [14:0] HALTED = 15'b0000_000000000_0_1;
  localparam logic [14:0] E_ADD  = 15'b0000_0_1_1_0_0_0_0_0_0_1_0;
  localparam logic [14:0] E_ADDI = 15'b1000_1_0_1_0_0_0_0_0_0_1_0;
  localparam logic [14:0] E_NOP  = 15'b0000_0_0_0_0_0_0_0_0_0_1_0;
  localparam logic [14:0] E_BEQ  = 15'b0100_0_0_0_0_0_0_1_0_0_1_0;
  localparam logic [31:0] I_ADD = 32'h00221820, I_ADDI = 32'h20010005, I_LW = 32'h8C220004;
  localparam logic [31:0] I_HALT = 32'hFC000000, I_BAD = 32'h7C000000;
  vec_t vecs[17];
  function automatic logic [14:0] got();
    return {alu_op, alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, branch, branch_ne, jump, o_valid, halted};
  endfunction
  task automatic check(input string name, input logic [14:0] exp);
    checks++;
    if (got() !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got(), exp);
    end
  endtask
  task automatic step(input logic [31:0] in, input logic v, input logic s, input logic f);
    @(negedge clk);
    instr = in; valid = v; stall = s; flush = f;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset", BUBBLE);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    vecs[0]  = '{I_ADD, 1, 0, 0, E_ADD, "add"};
    vecs[1]  = '{I_ADDI, 1, 0, 0, E_ADDI, "addi"};
    vecs[2]  = '{32'h34010005, 1, 0, 0, 15'b1101_1_0_1_0_0_0_0_0_0_1_0, "ori"};
    vecs[3]  = '{32'h28010005, 1, 0, 0, 15'b1010_1_0_1_0_0_0_0_0_0_1_0, "slti"};
    vecs[4]  = '{I_LW, 1, 0, 0, 15'b0001_1_0_1_1_0_1_0_0_0_1_0, "lw"};
    vecs[5]  = '{32'hAC220004, 1, 0, 0, 15'b0001_1_0_0_0_1_0_0_0_0_1_0, "sw"};
    vecs[6]  = '{I_ADD, 0, 0, 0, BUBBLE, "invalid_bubble"};
    vecs[7]  = '{32'h14220003, 1, 0, 0, 15'b0100_0_0_0_0_0_0_0_1_0_1_0, "bne"};
    vecs[8]  = '{32'h08000010, 1, 0, 0, 15'b0000_0_0_0_0_0_0_0_0_1_1_0, "j"};
    vecs[9]  = '{32'h0C000010, 1, 0, 0, 15'b0001_0_0_1_0_0_0_0_0_1_1_0, "jal"};
    vecs[10] = '{32'h3C010005, 1, 0, 0, 15'b1111_1_0_1_0_0_0_0_0_0_1_0, "lui"};
    vecs[11] = '{32'h00000000, 1, 0, 0, E_ADD, "sll_zero"};
    vecs[12] = '{32'h10220003, 1, 0, 0, E_BEQ, "beq"};
    vecs[13] = '{I_LW, 1, 1, 0, E_BEQ, "stall_hold1"};
    vecs[14] = '{I_LW, 1, 1, 0, E_BEQ, "stall_hold2"};
    vecs[15] = '{I_LW, 1, 1, 1, BUBBLE, "flush_over_stall"};
    vecs[16] = '{I_ADDI, 1, 0, 1, BUBBLE, "flush"};
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", BUBBLE);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      step(vecs[i].instr, vecs[i].valid, vecs[i].stall, vecs[i].flush);
      check(vecs[i].name, vecs[i].exp);
    end
    // HALT with one stalled drain cycle: halted exactly 5 edges after capture
    step(I_HALT, 1, 0, 0); check("halt_capture", BUBBLE);
    step(I_ADDI, 1, 0, 0); check("drain1", BUBBLE);
    step(I_ADDI, 1, 1, 0); check("drain_stall", BUBBLE);
    step(I_ADDI, 1, 0, 0); check("drain3", BUBBLE);
    step(I_ADDI, 1, 0, 0); check("drain4", BUBBLE);
    step(I_ADDI, 1, 0, 0); check("halted_edge5", HALTED);
    step(I_ADDI, 1, 0, 0); check("halted_hold", HALTED);
    step(I_ADDI, 1, 1, 0); check("halted_stall", HALTED);
    do_reset();
    step(I_ADD, 1, 0, 0); check("add_after_reset", E_ADD);
    // flushed HALT is discarded
    step(I_HALT, 1, 0, 1); check("halt_flushed", BUBBLE);
    for (int k = 0; k < 5; k++) step(I_ADDI, 1, 0, 0);
    check("no_halt_after_flush", E_ADDI);
    // reset mid-drain returns to RUN
    step(I_HALT, 1, 0, 0);
    step(I_ADDI, 1, 0, 0);
    do_reset();
    step(I_ADD, 1, 0, 0); check("add_after_mid_reset", E_ADD);
    for (int k = 0; k < 4; k++) step(I_ADDI, 1, 0, 0);
    check("run_after_mid_reset", E_ADDI);
    // unknown opcode
    step(I_BAD, 1, 0, 0);
`ifdef ILLEGAL_OPCODE_TRAP_EN
    check("illegal_bubble", BUBBLE);
    checks++;
    if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b expected 1", illegal); end
    for (int k = 0; k < 4; k++) step(I_ADDI, 1, 0, 0);
    check("illegal_drained", HALTED);
    checks++;
    if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b expected 1", illegal); end
`else
    check("unknown_nop", E_NOP);
    for (int k = 0; k < 4; k++) step(I_ADDI, 1, 0, 0);
    check("unknown_no_halt", E_ADDI);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
